// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between instruction fetch (IF) and
// the load/store data port (D). Each transaction is serialised onto the memory
// port. D has fixed priority. A starvation counter lets IF win once D has taken
// STARVE_LIMIT consecutive grants while IF was waiting.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack)
//   if_rdata/if_ack          fetch data and one-cycle completion pulse
//   d_req/d_we/d_be/d_addr/d_wdata
//                            load/store request (held until d_ack)
//   d_rdata/d_ack            load data (unchanged by stores) and completion pulse
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata
//                            memory request, held stable until mem_ack
//   mem_rdata/mem_ack        memory read data and completion
//   busy                     high while a transaction is in flight
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;

    logic               mem_req_nxt;
    logic               mem_we_nxt;
    logic [BE_W-1:0]    mem_be_nxt;
    logic [ADDR_W-1:0]  mem_addr_nxt;
    logic [DATA_W-1:0]  mem_wdata_nxt;
    logic               if_ack_nxt;
    logic               d_ack_nxt;
    logic [DATA_W-1:0]  if_rdata_nxt;
    logic [DATA_W-1:0]  d_rdata_nxt;

    // A requester still sees its own ack in the cycle after completion and has
    // not yet had a chance to drop req; masking it avoids a duplicate issue.
    logic eligible_i, eligible_d, starved;

    assign eligible_i = if_req & ~if_ack;
    assign eligible_d = d_req  & ~d_ack;
    assign starved    = eligible_i && (starve_cnt == CNT_MAX);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        mem_req_nxt    = mem_req;
        mem_we_nxt     = mem_we;
        mem_be_nxt     = mem_be;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        if_ack_nxt     = 1'b0;
        d_ack_nxt      = 1'b0;
        if_rdata_nxt   = if_rdata;
        d_rdata_nxt    = d_rdata;

        case (state)
            IDLE: begin
                // IF not waiting: any D streak so far did not starve anyone.
                if (!if_req) begin
                    starve_cnt_nxt = '0;
                end

                if (eligible_d && !starved) begin
                    state_nxt     = BUSY_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_be_nxt    = d_be;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    if (if_req && (starve_cnt != CNT_MAX)) begin
                        starve_cnt_nxt = starve_cnt + CNT_W'(1);
                    end
                end else if (eligible_i) begin
                    state_nxt      = BUSY_I;
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = 1'b0;
                    mem_be_nxt     = '1;
                    mem_addr_nxt   = if_addr;
                    mem_wdata_nxt  = '0;
                    starve_cnt_nxt = '0;
                end
            end

            BUSY_I: begin
                if (mem_ack) begin
                    state_nxt    = IDLE;
                    mem_req_nxt  = 1'b0;
                    if_ack_nxt   = 1'b1;
                    if_rdata_nxt = mem_rdata;
                end
            end

            BUSY_D: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    // Stores leave the last load result visible.
                    if (!mem_we) begin
                        d_rdata_nxt = mem_rdata;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Reset abandons any in-flight transaction: mem_req drops and no ack is
    // produced for it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_be     <= mem_be_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_ack     <= if_ack_nxt;
            d_ack      <= d_ack_nxt;
            if_rdata   <= if_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule
